// File: rtl/hex_7seg_scan_driver.sv
// Purpose: time-multiplexed N-digit hex display driver for a common-anode 7-segment display.
// Latency: outputs registered, one cycle behind the tick counter, digit index and shadow regs.
// Backpressure: none; load is a one-cycle strobe, always accepted, and the scan never stalls except via enable.
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN (blank leading zero digits captured at load).
module hex_7seg_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   data_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     blank_in,
    output logic [6:0]                seg_n,
    output logic                      dp_n,
    output logic [NUM_DIGITS-1:0]     an_n
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0]         CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0]         IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE   = NUM_DIGITS'(1);

    // Hex nibble to abcdefg pattern, segment a in bit 6, active-high.
    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h7E;
            4'h1: s = 7'h30;
            4'h2: s = 7'h6D;
            4'h3: s = 7'h79;
            4'h4: s = 7'h33;
            4'h5: s = 7'h5B;
            4'h6: s = 7'h5F;
            4'h7: s = 7'h70;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h7B;
            4'hA: s = 7'h77;
            4'hB: s = 7'h1F;
            4'hC: s = 7'h4E;
            4'hD: s = 7'h3D;
            4'hE: s = 7'h4F;
            default: s = 7'h47;
        endcase
        return s;
    endfunction

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] shadow_data;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [NUM_DIGITS-1:0]   shadow_blank;

    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_blank;
    logic                    cur_lz;

    logic [6:0]              seg_nxt;
    logic                    dp_nxt;
    logic [NUM_DIGITS-1:0]   an_nxt;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [NUM_DIGITS-1:0]   shadow_lz;
    logic                    nz_seen;

    // Walk from the MSB digit down; zeros are blanked until the first nonzero nibble, digit 0 never.
    always_comb begin
        lz_mask = '0;
        nz_seen = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (data_in[4*k +: 4] != 4'h0) begin
                nz_seen = 1'b1;
            end
            lz_mask[k] = !nz_seen;
        end
    end

    // Leading-zero mask is captured alongside the data it was derived from.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_lz <= '0;
        end else if (load) begin
            shadow_lz <= lz_mask;
        end
    end

    assign cur_lz = shadow_lz[idx];
`else
    assign cur_lz = 1'b0;
`endif

    // Shadow registers: capture the display word on load, independent of enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_data  <= '0;
            shadow_dp    <= '0;
            shadow_blank <= '0;
        end else if (load) begin
            shadow_data  <= data_in;
            shadow_dp    <= dp_in;
            shadow_blank <= blank_in;
        end
    end

    // Slot timer and digit index; both freeze while enable is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (enable) begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign cur_nib   = shadow_data[{idx, 2'b00} +: 4];
    assign cur_dp    = shadow_dp[idx];
    assign cur_blank = shadow_blank[idx];

    // Next display state: dark when disabled or in the first (anti-ghost) cycle of a slot.
    always_comb begin
        seg_nxt = 7'h7F;
        dp_nxt  = 1'b1;
        an_nxt  = '1;
        if (enable && (cnt != '0)) begin
            an_nxt = ~(AN_ONE << idx);
            if (!cur_blank) begin
                dp_nxt = ~cur_dp;
                if (!cur_lz) begin
                    seg_nxt = ~hex_decode(cur_nib);
                end
            end
        end
    end

    // Registered outputs; reset forces the display dark immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_n <= 7'h7F;
            dp_n  <= 1'b1;
            an_n  <= '1;
        end else begin
            seg_n <= seg_nxt;
            dp_n  <= dp_nxt;
            an_n  <= an_nxt;
        end
    end

endmodule

// File: tb/tb_hex_7seg_scan_driver.sv
// Bench for hex_7seg_scan_driver with NUM_DIGITS=4, REFRESH_DIV=4.
// A cycle-level model derived from elapsed enabled cycles is compared every cycle,
// plus directed checks with hand-computed literal values.
module tb_hex_7seg_scan_driver;

    localparam int N = 4;
    localparam int D = 4;

    logic         clk;
    logic         reset_n;
    logic         enable;
    logic         load;
    logic [15:0]  data_in;
    logic [3:0]   dp_in;
    logic [3:0]   blank_in;
    logic [6:0]   seg_n;
    logic         dp_n;
    logic [3:0]   an_n;

    int total = 0;
    int bad   = 0;

    hex_7seg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(D)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .load     (load),
        .data_in  (data_in),
        .dp_in    (dp_in),
        .blank_in (blank_in),
        .seg_n    (seg_n),
        .dp_n     (dp_n),
        .an_n     (an_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Segment patterns for hex digits (abcdefg, a = bit 6), active-high.
    function automatic logic [6:0] seg_of(input logic [3:0] v);
        logic [6:0] tbl [16];
        tbl = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
        return tbl[v];
    endfunction

    // Model state: the scan position is fully determined by the number of enabled cycles since reset.
    int          en_cycles = 0;
    logic [15:0] m_data  = '0;
    logic [3:0]  m_dp    = '0;
    logic [3:0]  m_blank = '0;
    logic [3:0]  m_lz    = '0;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  e_an;

    always @(posedge clk) begin
        int phase;
        int didx;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
        e_an  = 4'hF;
        if (!reset_n) begin
            en_cycles = 0;
            m_data    = '0;
            m_dp      = '0;
            m_blank   = '0;
            m_lz      = '0;
        end else begin
            phase = en_cycles % D;
            didx  = (en_cycles / D) % N;
            if (enable && phase != 0) begin
                e_an = 4'hF ^ (4'h1 << didx);
                if (!m_blank[didx]) begin
                    e_dp = ~m_dp[didx];
                    if (!m_lz[didx]) e_seg = ~seg_of(m_data[4*didx +: 4]);
                end
            end
            if (enable) en_cycles++;
            if (load) begin
                m_data  = data_in;
                m_dp    = dp_in;
                m_blank = blank_in;
                m_lz    = '0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
                for (int k = 1; k < N; k++) m_lz[k] = ((data_in >> (4*k)) == 16'h0);
`endif
            end
        end
        #1;
        chk("model an_n", 32'(an_n), 32'(e_an));
        chk("model seg_n", 32'(seg_n), 32'(e_seg));
        chk("model dp_n", 32'(dp_n), 32'(e_dp));
    end

    // Wait (bounded) until the given anode pattern is on the outputs.
    task automatic wait_an(input logic [3:0] a);
        int i;
        i = 0;
        @(negedge clk);
        while (an_n !== a && i < 200) begin
            @(negedge clk);
            i++;
        end
        if (i >= 200) chk("wait_an timeout", 32'(an_n), 32'(a));
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
        @(negedge clk);
        data_in  = d;
        dp_in    = dp;
        blank_in = bl;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset_n  = 1'b0;
        enable   = 1'b1;
        load     = 1'b0;
        data_in  = '0;
        dp_in    = '0;
        blank_in = '0;
        repeat (3) @(negedge clk);
        chk("reset an_n", 32'(an_n), 32'hF);
        chk("reset seg_n", 32'(seg_n), 32'h7F);
        chk("reset dp_n", 32'(dp_n), 32'h1);

        // Release: one dark cycle, then digit 0 shows "0".
        reset_n = 1'b1;
        @(negedge clk);
        chk("release blank an_n", 32'(an_n), 32'hF);
        @(negedge clk);
        chk("release digit0 an_n", 32'(an_n), 32'hE);
        chk("release digit0 seg_n", 32'(seg_n), 32'h01);

        // Mixed digits with one decimal point.
        do_load(16'h1A2F, 4'b0100, 4'b0000);
        wait_an(4'hE);
        chk("1A2F d0 seg", 32'(seg_n), 32'h38);
        chk("1A2F d0 dp", 32'(dp_n), 32'h1);
        wait_an(4'hD);
        chk("1A2F d1 seg", 32'(seg_n), 32'h12);
        wait_an(4'hB);
        chk("1A2F d2 seg", 32'(seg_n), 32'h08);
        chk("1A2F d2 dp", 32'(dp_n), 32'h0);
        wait_an(4'h7);
        chk("1A2F d3 seg", 32'(seg_n), 32'h4F);

        // Pause mid-slot on digit 2.
        wait_an(4'hB);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("disabled an_n", 32'(an_n), 32'hF);
        end
        enable = 1'b1;
        @(negedge clk);
        chk("resume digit2 an_n", 32'(an_n), 32'hB);

        // Blanked digit keeps its anode slot but shows nothing.
        do_load(16'h8888, 4'b0000, 4'b1000);
        wait_an(4'h7);
        chk("blank d3 seg", 32'(seg_n), 32'h7F);
        chk("blank d3 dp", 32'(dp_n), 32'h1);
        wait_an(4'hE);
        chk("blank d0 seg", 32'(seg_n), 32'h00);

        // Asynchronous reset mid-slot on digit 3.
        wait_an(4'h7);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async reset an_n", 32'(an_n), 32'hF);
        chk("async reset seg_n", 32'(seg_n), 32'h7F);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("restart an_n", 32'(an_n), 32'hE);
        chk("restart seg_n cleared", 32'(seg_n), 32'h01);

`ifdef SEG7_LEADING_ZERO_BLANK_EN
        do_load(16'h0070, 4'b0000, 4'b0000);
        wait_an(4'h7);
        chk("lz 0070 d3", 32'(seg_n), 32'h7F);
        wait_an(4'hB);
        chk("lz 0070 d2", 32'(seg_n), 32'h7F);
        wait_an(4'hD);
        chk("lz 0070 d1", 32'(seg_n), 32'h0F);
        wait_an(4'hE);
        chk("lz 0070 d0", 32'(seg_n), 32'h01);
        do_load(16'h0000, 4'b0000, 4'b0000);
        wait_an(4'hD);
        chk("lz 0000 d1", 32'(seg_n), 32'h7F);
        wait_an(4'hE);
        chk("lz 0000 d0", 32'(seg_n), 32'h01);
`else
        do_load(16'h0070, 4'b0000, 4'b0000);
        wait_an(4'h7);
        chk("no-lz 0070 d3", 32'(seg_n), 32'h01);
        wait_an(4'hD);
        chk("no-lz 0070 d1", 32'(seg_n), 32'h0F);
`endif

        // Random traffic; the per-cycle model check covers every cycle.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!reset_n) begin
                reset_n = 1'b1;
            end else if ($urandom_range(0, 499) == 0) begin
                reset_n = 1'b0;
            end
            enable   = ($urandom_range(0, 7) != 0);
            load     = ($urandom_range(0, 15) == 0);
            data_in  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            dp_in    = 4'($urandom);
            blank_in = 4'($urandom) & 4'($urandom);
        end
        @(negedge clk);
        load = 1'b0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
